button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 123 ++++++++++++
 tb/tb_button_debouncer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchronizer followed by a four-state
// qualification FSM. A level change is accepted only after DEBOUNCE_CYCLES
// consecutive matching samples; any contrary sample aborts the change and
// bumps a saturating glitch counter.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_raw,
  output logic       button_level,
  output logic       bouncing,
  output logic [7:0] glitch_count
);

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'b00,
    CHECK_HIGH  = 2'b01,
    HIGH_STABLE = 2'b11,
    CHECK_LOW   = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_d, sync1_q;
  logic             sync2_d, sync2_q;
  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [7:0]       glitch_d, glitch_q;
  logic [7:0]       glitch_inc;
  logic             s;

  // Synchronizer inputs: raw level into stage 1, stage 1 into stage 2.
  always_comb begin
    sync1_d = button_raw;
    sync2_d = sync1_q;
  end

  assign s = sync2_q;

  // Saturating increment: a glitch seen at 255 leaves the count at 255.
  always_comb begin
    glitch_inc = (glitch_q == 8'hFF) ? glitch_q : glitch_q + 8'd1;
  end

  // State register, counters and synchronizer flops.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse the synchronizer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= LOW_STABLE;
      cnt_q    <= '0;
      glitch_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
    end
  end

  // Next-state logic: qualify candidate level changes on the synchronized sample.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    unique case (state_q)
      LOW_STABLE: begin
        if (s) begin
          state_d = CHECK_HIGH;
          cnt_d   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!s) begin
          state_d  = LOW_STABLE;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH_STABLE: begin
        if (!s) begin
          state_d = CHECK_LOW;
          cnt_d   = '0;
        end
      end
      CHECK_LOW: begin
        if (s) begin
          state_d  = HIGH_STABLE;
          cnt_d    = '0;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from registered state only; nothing combinational from button_raw.
  always_comb begin
    button_level = (state_q == HIGH_STABLE) || (state_q == CHECK_LOW);
    bouncing     = (state_q == CHECK_HIGH)  || (state_q == CHECK_LOW);
    glitch_count = glitch_q;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4.
// Edge numbers in the expectations count rising clk edges after the
// stimulus change; inputs change and outputs are sampled 1ns after an edge.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       button_raw = 1'b0;
  logic       button_level;
  logic       bouncing;
  logic [7:0] glitch_count;

  int errors = 0;
  int checks = 0;

  button_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .button_raw   (button_raw),
    .button_level (button_level),
    .bouncing     (bouncing),
    .glitch_count (glitch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    if (button_level !== 1'b0) begin
      $display("FAIL reset_level got=%b exp=0", button_level); errors++;
    end
    checks++;
    if (bouncing !== 1'b0) begin
      $display("FAIL reset_bouncing got=%b exp=0", bouncing); errors++;
    end
    checks++;
    if (glitch_count !== 8'd0) begin
      $display("FAIL reset_glitch got=%0d exp=0", glitch_count); errors++;
    end
    checks++;
    button_raw = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    if ({button_level, bouncing} !== 2'b00) begin
      $display("FAIL reset_hold got=%b%b exp=00", button_level, bouncing); errors++;
    end
    checks++;
    button_raw = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    if ({button_level, bouncing, glitch_count} !== 10'd0) begin
      $display("FAIL reset_idle got=%b%b/%0d exp=00/0", button_level, bouncing, glitch_count);
      errors++;
    end
    checks++;
  endtask

  task automatic test_clean_press();
    button_raw = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (button_level !== (e >= 7)) begin
        $display("FAIL press_level edge=%0d got=%b exp=%b", e, button_level, (e >= 7)); errors++;
      end
      checks++;
      if (bouncing !== (e >= 3 && e <= 6)) begin
        $display("FAIL press_bouncing edge=%0d got=%b exp=%b", e, bouncing, (e >= 3 && e <= 6));
        errors++;
      end
      checks++;
    end
    if (glitch_count !== 8'd0) begin
      $display("FAIL press_glitch got=%0d exp=0", glitch_count); errors++;
    end
    checks++;
  endtask

  task automatic test_release();
    // Clean release from HIGH_STABLE.
    button_raw = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (button_level !== (e < 7)) begin
        $display("FAIL release_level edge=%0d got=%b exp=%b", e, button_level, (e < 7)); errors++;
      end
      checks++;
      if (bouncing !== (e >= 3 && e <= 6)) begin
        $display("FAIL release_bouncing edge=%0d got=%b exp=%b", e, bouncing, (e >= 3 && e <= 6));
        errors++;
      end
      checks++;
    end
    // Press again, then release with a one-sample high blip inside CHECK_LOW.
    button_raw = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    if (button_level !== 1'b1) begin
      $display("FAIL repress_level got=%b exp=1", button_level); errors++;
    end
    checks++;
    for (int e = 1; e <= 12; e++) begin
      button_raw = (e == 4);
      tick();
      if (button_level !== (e < 11)) begin
        $display("FAIL blip_level edge=%0d got=%b exp=%b", e, button_level, (e < 11)); errors++;
      end
      checks++;
      if (bouncing !== ((e >= 3 && e <= 5) || (e >= 7 && e <= 10))) begin
        $display("FAIL blip_bouncing edge=%0d got=%b", e, bouncing); errors++;
      end
      checks++;
      if (glitch_count !== ((e < 6) ? 8'd0 : 8'd1)) begin
        $display("FAIL blip_glitch edge=%0d got=%0d exp=%0d", e, glitch_count, (e < 6) ? 0 : 1);
        errors++;
      end
      checks++;
    end
  endtask

  task automatic test_bounce();
    // High 2 samples, low 1 sample, then high and held (glitch_count starts at 1).
    for (int e = 1; e <= 14; e++) begin
      button_raw = (e != 3);
      tick();
      if (button_level !== (e >= 10)) begin
        $display("FAIL bounce_level edge=%0d got=%b exp=%b", e, button_level, (e >= 10)); errors++;
      end
      checks++;
      if (bouncing !== ((e >= 3 && e <= 4) || (e >= 6 && e <= 9))) begin
        $display("FAIL bounce_bouncing edge=%0d got=%b", e, bouncing); errors++;
      end
      checks++;
      if (glitch_count !== ((e < 5) ? 8'd1 : 8'd2)) begin
        $display("FAIL bounce_glitch edge=%0d got=%0d exp=%0d", e, glitch_count, (e < 5) ? 1 : 2);
        errors++;
      end
      checks++;
    end
    button_raw = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    if (button_level !== 1'b0) begin
      $display("FAIL bounce_release got=%b exp=0", button_level); errors++;
    end
    checks++;
  endtask

  task automatic test_short_pulse();
    // Pulse entirely between two edges: never sampled, nothing changes.
    #2 button_raw = 1'b1;
    #3 button_raw = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if ({button_level, bouncing} !== 2'b00 || glitch_count !== 8'd2) begin
        $display("FAIL narrow_pulse edge=%0d got=%b%b/%0d exp=00/2", e, button_level, bouncing,
                 glitch_count);
        errors++;
      end
      checks++;
    end
    // Pulse caught by exactly one edge: one aborted qualification.
    for (int e = 1; e <= 8; e++) begin
      button_raw = (e == 1);
      tick();
      if (button_level !== 1'b0) begin
        $display("FAIL one_sample_level edge=%0d got=%b exp=0", e, button_level); errors++;
      end
      checks++;
    end
    if (glitch_count !== 8'd3) begin
      $display("FAIL one_sample_glitch got=%0d exp=3", glitch_count); errors++;
    end
    checks++;
  endtask

  task automatic toggle_aborts(input int k);
    for (int e = 1; e <= 2 * k; e++) begin
      button_raw = e[0];
      tick();
    end
    button_raw = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_saturation();
    toggle_aborts(10);
    if (glitch_count !== 8'd13) begin
      $display("FAIL sat_partial got=%0d exp=13", glitch_count); errors++;
    end
    checks++;
    toggle_aborts(300);
    if (glitch_count !== 8'd255) begin
      $display("FAIL sat_reached got=%0d exp=255", glitch_count); errors++;
    end
    checks++;
    if ({button_level, bouncing} !== 2'b00) begin
      $display("FAIL sat_outputs got=%b%b exp=00", button_level, bouncing); errors++;
    end
    checks++;
    toggle_aborts(5);
    if (glitch_count !== 8'd255) begin
      $display("FAIL sat_hold got=%0d exp=255", glitch_count); errors++;
    end
    checks++;
  endtask

  task automatic test_async_reset();
    button_raw = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    if (bouncing !== 1'b1) begin
      $display("FAIL areset_pre_bouncing got=%b exp=1", bouncing); errors++;
    end
    checks++;
    #2 reset = 1'b0;
    #1;
    if ({button_level, bouncing} !== 2'b00 || glitch_count !== 8'd0) begin
      $display("FAIL areset_immediate got=%b%b/%0d exp=00/0", button_level, bouncing,
               glitch_count);
      errors++;
    end
    checks++;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (button_level !== (e >= 7)) begin
        $display("FAIL areset_level edge=%0d got=%b exp=%b", e, button_level, (e >= 7)); errors++;
      end
      checks++;
      if (bouncing !== (e >= 3 && e <= 6)) begin
        $display("FAIL areset_bouncing edge=%0d got=%b exp=%b", e, bouncing, (e >= 3 && e <= 6));
        errors++;
      end
      checks++;
    end
    if (glitch_count !== 8'd0) begin
      $display("FAIL areset_glitch got=%0d exp=0", glitch_count); errors++;
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_short_pulse();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
